// File: rtl/pipe_cla_pkg.sv
// Shared constants and types for the pipelined carry-lookahead adder.
package pipe_cla_pkg;
  localparam int GROUP_W = 4;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;
endpackage

// File: rtl/cla_group.sv
// 4-bit generate/propagate lookahead group: sum, carry-out and carry into its MSB.
module cla_group
  import pipe_cla_pkg::*;
(
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               ci,
  output logic [GROUP_W-1:0] s,
  output logic               co,
  output logic               cm
);
  logic [GROUP_W-1:0] g;
  logic [GROUP_W-1:0] p;
  logic [GROUP_W:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c    = '0;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
  end

  assign s  = p ^ c[GROUP_W-1:0];
  assign co = c[GROUP_W];
  assign cm = c[GROUP_W-1];
endmodule

// File: rtl/pipe_cla_adder.sv
// Pipelined add/subtract, one WIDTH/STAGES slice per stage with elastic handshake.
// Optional N/Z/C/V flags are built only when PIPE_CLA_FLAGS_EN is defined.
module pipe_cla_adder
  import pipe_cla_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic [3:0]       flags
);
  localparam int SLICE_W = WIDTH / STAGES;
  localparam int GROUPS  = SLICE_W / GROUP_W;

  logic [STAGES-1:0]  vld_p;
  logic [STAGES-1:0]  adv;
  logic               full_run;

  // acc_p rotates right one slice per stage: finished sum slices enter at the
  // top while the pending a slice is always at the bottom, so after the last
  // stage the sum sits in place.
  logic [WIDTH-1:0]   acc_p   [STAGES];
  logic [WIDTH-1:0]   bsh_p   [STAGES-1];
  logic               cy_p    [STAGES-1];

  logic [WIDTH-1:0]   a_in    [STAGES];
  logic [WIDTH-1:0]   b_in    [STAGES];
  logic               c_in    [STAGES];
  logic [SLICE_W-1:0] slice_s [STAGES];
  logic               slice_co[STAGES];
  logic [GROUPS-1:0]  ci_msb  [STAGES];
  logic               unused_bits;

  // A stage may load when it, or any stage below the output, has a free slot.
  always_comb begin
    full_run = 1'b1;
    adv      = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      full_run = full_run & vld_p[k];
      adv[k]   = out_ready | ~full_run;
    end
  end

  assign in_ready = adv[0] & ~reset;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [GROUPS:0] gc;

    if (k == 0) begin : g_first
      assign a_in[k] = a;
      assign b_in[k] = sub ? ~b : b;
      assign c_in[k] = sub | cin;
    end else begin : g_next
      assign a_in[k] = acc_p[k-1];
      assign b_in[k] = bsh_p[k-1];
      assign c_in[k] = cy_p[k-1];
    end

    assign gc[0] = c_in[k];
    for (genvar g = 0; g < GROUPS; g++) begin : g_grp
      cla_group u_grp (
        .a  (a_in[k][g*GROUP_W +: GROUP_W]),
        .b  (b_in[k][g*GROUP_W +: GROUP_W]),
        .ci (gc[g]),
        .s  (slice_s[k][g*GROUP_W +: GROUP_W]),
        .co (gc[g+1]),
        .cm (ci_msb[k][g])
      );
    end
    assign slice_co[k] = gc[GROUPS];
  end

  // Carry-into-group-MSB is only consumed for V in the last group of the last stage.
  always_comb begin
    unused_bits = (^b_in[STAGES-1]) ^ slice_co[STAGES-1];
    for (int k = 0; k < STAGES; k++) begin
      unused_bits = unused_bits ^ (^ci_msb[k]);
    end
  end

  // ---- stage boundary: valid bits ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p <= '0;
    end else begin
      if (adv[0]) vld_p[0] <= in_valid & in_ready;
      for (int k = 1; k < STAGES; k++) begin
        if (adv[k]) vld_p[k] <= vld_p[k-1];
      end
    end
  end

  // ---- stage boundary: data registers ----
  always_ff @(posedge clk) begin
    for (int k = 0; k < STAGES; k++) begin
      if (adv[k]) acc_p[k] <= {slice_s[k], a_in[k][WIDTH-1:SLICE_W]};
    end
    for (int k = 0; k < STAGES - 1; k++) begin
      if (adv[k]) begin
        bsh_p[k] <= {{SLICE_W{1'b0}}, b_in[k][WIDTH-1:SLICE_W]};
        cy_p[k]  <= slice_co[k];
      end
    end
  end

  assign out_valid = vld_p[STAGES-1];
  assign sum       = vld_p[STAGES-1] ? acc_p[STAGES-1] : '0;

`ifdef PIPE_CLA_FLAGS_EN
  logic   z_p [STAGES-1];
  logic   zc  [STAGES];
  flags_t fl_p;

  // Zero detect is accumulated one slice per stage.
  always_comb begin
    zc[0] = ~(|slice_s[0]);
    for (int k = 1; k < STAGES; k++) begin
      zc[k] = z_p[k-1] & ~(|slice_s[k]);
    end
  end

  // ---- stage boundary: flag registers ----
  always_ff @(posedge clk) begin
    for (int k = 0; k < STAGES - 1; k++) begin
      if (adv[k]) z_p[k] <= zc[k];
    end
    if (adv[STAGES-1]) begin
      fl_p.n <= slice_s[STAGES-1][SLICE_W-1];
      fl_p.z <= zc[STAGES-1];
      fl_p.c <= slice_co[STAGES-1];
      fl_p.v <= slice_co[STAGES-1] ^ ci_msb[STAGES-1][GROUPS-1];
    end
  end

  assign flags = vld_p[STAGES-1] ? fl_p : 4'b0000;
`else
  assign flags = 4'b0000;
`endif
endmodule

// File: tb/tb_pipe_cla_adder.sv
// Scoreboard bench for pipe_cla_adder (WIDTH=64, STAGES=4) with directed vectors.
module tb_pipe_cla_adder;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic [3:0]   flags;

  pipe_cla_adder #(.WIDTH(64), .STAGES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] s;
    logic [3:0]  f;
    bit          lat;
    bit          gap;
  } exp_t;

  exp_t sb[$];
  int   acc_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic logic [3:0] fx(input logic [3:0] f);
`ifdef PIPE_CLA_FLAGS_EN
    fx = f;
`else
    fx = f & 4'b0000;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: pops the scoreboard whenever a result is consumed.
  logic        prev_stall = 1'b0;
  logic [63:0] prev_sum;
  logic [3:0]  prev_flags;
  int          last_out = -10;
  exp_t        e;
  int          t;

  always @(negedge clk) begin
    if (!reset && in_valid && in_ready) acc_q.push_back(cyc);
    if (prev_stall) begin
      check("stall_valid", {63'b0, out_valid}, 64'd1);
      check("stall_sum", sum, prev_sum);
      check("stall_flags", {60'b0, flags}, {60'b0, prev_flags});
    end
    prev_stall = out_valid && !out_ready && !reset;
    prev_sum   = sum;
    prev_flags = flags;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output: got sum %h with no result pending", sum);
      end else begin
        e = sb.pop_front();
        t = (acc_q.size() > 0) ? acc_q.pop_front() : -100;
        check("sum", sum, e.s);
        check("flags", {60'b0, flags}, {60'b0, e.f});
        if (e.lat) check("latency", 64'(cyc - t), 64'd4);
        if (e.gap) check("no_gap", 64'(cyc - last_out), 64'd1);
      end
      last_out = cyc;
    end
  end

  task automatic send(input logic [63:0] ta, input logic [63:0] tb, input logic tc,
                      input logic ts, input logic [63:0] es, input logic [3:0] ef,
                      input bit lat, input bit gap);
    int guard = 0;
    a = ta;
    b = tb;
    cin = tc;
    sub = ts;
    in_valid = 1'b1;
    sb.push_back('{es, fx(ef), lat, gap});
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready %b required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() > 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;
    reset     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_sum", sum, 64'd0);
    check("rst_flags", {60'b0, flags}, 64'd0);
    check("rst_in_ready", {63'b0, in_ready}, 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("idle_in_ready", {63'b0, in_ready}, 64'd1);

    // Directed vectors, out_ready held high.
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 4'b0110, 1'b1, 1'b0);
    drain();
    send(64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 1'b1, 1'b0);
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 4'b1001, 1'b1, 1'b0);
    send(64'd5, 64'd7, 1'b1, 1'b0, 64'd13, 4'b0000, 1'b1, 1'b0);
    send(64'd10, 64'd3, 1'b1, 1'b1, 64'd7, 4'b0010, 1'b1, 1'b0);
    send(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011, 1'b1, 1'b0);
    send(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 4'b0000, 1'b1, 1'b0);
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
         64'hFFFF_FFFF_FFFF_FFFF, 4'b1010, 1'b1, 1'b0);
    drain();

    // Back-to-back with an output stall.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send(64'(i), 64'(i), 1'b0, 1'b0, 64'(2 * i), (i == 0) ? 4'b0100 : 4'b0000,
               1'b0, i > 0);
        end
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("full_in_ready", {63'b0, in_ready}, 64'd0);
        check("full_out_valid", {63'b0, out_valid}, 64'd1);
        check("full_head_sum", sum, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three operations in flight.
    send(64'd100, 64'd1, 1'b0, 1'b0, 64'd101, 4'b0000, 1'b0, 1'b0);
    send(64'd200, 64'd2, 1'b0, 1'b0, 64'd202, 4'b0000, 1'b0, 1'b0);
    send(64'd300, 64'd3, 1'b0, 1'b0, 64'd303, 4'b0000, 1'b0, 1'b0);
    reset = 1'b1;
    sb.delete();
    acc_q.delete();
    #1;
    check("mid_rst_in_ready", {63'b0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    check("mid_rst_out_valid", {63'b0, out_valid}, 64'd0);
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("post_rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("post_rst_sum", sum, 64'd0);
    check("post_rst_flags", {60'b0, flags}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_cla_adder.md
PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 64: operand width in bits; a multiple of 4 and of 4*STAGES.
REQ-002 SHALL have parameter STAGES, default 4: pipeline depth; each stage resolves WIDTH/STAGES bits.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: operand set offered.
REQ-006 SHALL have port in_ready, output, 1 bit: operand set accepted when in_valid && in_ready.
REQ-007 SHALL have port a and port b, input, WIDTH bits each: operands.
REQ-008 SHALL have port cin, input, 1 bit: carry-in; ignored when sub=1.
REQ-009 SHALL have port sub, input, 1 bit: 1 selects a - b.
REQ-010 SHALL have port out_valid, output, 1 bit: result valid.
REQ-011 SHALL have port out_ready, input, 1 bit: result consumed when out_valid && out_ready.
REQ-012 SHALL have port sum, output, WIDTH bits: result.
REQ-013 SHALL have port flags, output, 4 bits: {N,Z,C,V}.

Function
REQ-014 SHALL compute sum = a + b' + c0 mod 2^WIDTH, where b' = sub ? ~b : b and c0 = sub ? 1 : cin.
REQ-015 SHALL split the word into STAGES slices; stage k adds slice k using 4-bit lookahead groups (G=a&b', P=a^b') rippled between groups, with the slice carry-in registered from stage k-1.
REQ-016 SHALL carry the unprocessed upper operand bits and the completed lower sum bits forward in pipeline registers, one valid bit per stage.
REQ-017 SHALL have a latency of exactly STAGES cycles from acceptance to out_valid when out_ready is held at 1.
REQ-018 SHALL sustain a throughput of one operation per cycle when out_ready is held at 1.
REQ-019 SHALL advance stage k when stage k is empty or stage k+1 advances (the output stage advances on out_ready); in_ready SHALL equal the advance condition of stage 0.
REQ-020 SHALL hold sum, flags and out_valid stable while out_valid && !out_ready.
REQ-021 SHALL deliver results in acceptance order with no loss or duplication; at most STAGES operations are in flight.
REQ-022 SHALL allow simultaneous acceptance and output in the same cycle when full and out_ready=1.
REQ-023 SHALL hold the flags as N = sum[WIDTH-1], Z = (sum==0), C = carry out of bit WIDTH-1, V = carry into MSB XOR carry out of MSB.

Reset
REQ-024 SHALL clear all stage valid bits on reset; out_valid SHALL read 0 in the cycle after reset is sampled.
REQ-025 SHALL drive sum=0 and flags=0 out of reset.
REQ-026 SHALL discard in-flight operations when reset is asserted mid-operation, and SHALL not accept input while reset=1 (in_ready=0).

Configuration
REQ-027 SHALL compute flags per REQ-023 when macro PIPE_CLA_FLAGS_EN is defined.
REQ-028 SHALL tie flags to 4'b0000 with no flag logic or registers when PIPE_CLA_FLAGS_EN is undefined; sum and handshake are unchanged.

Structure
REQ-029 SHALL place the GROUP_W=4 constant, the flag bit indices (N=3, Z=2, C=1, V=0) and a flags struct typedef in package pipe_cla_pkg.
REQ-030 SHALL instantiate sub-module cla_group (4-bit generate/propagate lookahead, carry-in to sum plus carry-out and MSB carry-in) once per group.
REQ-031 SHALL give Z a per-stage registered "slice all-zero" bit ANDed across stages, so no WIDTH-wide reduction sits in one stage.

Verification (WIDTH=64, STAGES=4, macro defined unless noted)
REQ-032 SHALL cover a=FFFF_FFFF_FFFF_FFFF, b=1, cin=0, sub=0 -> sum=0, flags N0 Z1 C1 V0, out_valid exactly 4 cycles after acceptance.
REQ-033 SHALL cover a=5, b=7, sub=1 -> sum=FFFF_FFFF_FFFF_FFFE, flags N1 Z0 C0 V0.
REQ-034 SHALL cover a=7FFF_FFFF_FFFF_FFFF, b=1, sub=0 -> sum=8000_0000_0000_0000, flags N1 Z0 C0 V1.
REQ-035 SHALL cover 8 back-to-back operations (a=i, b=i), with out_ready=0 for cycles 2..9 -> in_ready drops after 4 in flight, output stable while stalled, then results 0,2,4,...,14 in order with no gaps.
REQ-036 SHALL cover reset asserted with 3 operations in flight -> out_valid=0 next cycle and none of the 3 results ever emerges.
REQ-037 SHALL cover the macro undefined with REQ-034 stimulus -> sum=8000_0000_0000_0000, flags=0.
